// File: rtl/philv_pkg.sv
// Shared definitions for the PhilosophyV control/execute slice: ALU codes,
// opcodes, controller states, operand-select encodings and instruction fields.
package philv_pkg;

   localparam int BUS_WIDTH       = 32;
   localparam int ALU_FUNCT_WIDTH = 4;

   typedef enum logic [ALU_FUNCT_WIDTH-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_funct_e;

   typedef enum logic [1:0] {
      ST_FETCH     = 2'd0,
      ST_DECODE    = 2'd1,
      ST_EXECUTE   = 2'd2,
      ST_WRITEBACK = 2'd3
   } state_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

   localparam logic       SRC_A_PC   = 1'b0;
   localparam logic       SRC_A_RS1  = 1'b1;
   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;
   localparam logic [1:0] SRC_B_ZERO = 2'b11;

   // Instruction field bit ranges
   localparam int OPCODE_LSB = 0;
   localparam int OPCODE_MSB = 6;
   localparam int RD_LSB     = 7;
   localparam int RD_MSB     = 11;
   localparam int FUNCT3_LSB = 12;
   localparam int FUNCT3_MSB = 14;
   localparam int RS1_LSB    = 15;
   localparam int RS1_MSB    = 19;
   localparam int RS2_LSB    = 20;
   localparam int RS2_MSB    = 24;
   localparam int FUNCT7_LSB = 25;
   localparam int FUNCT7_MSB = 31;

   // True for the opcodes this core executes (register and immediate ALU ops).
   function automatic logic is_supported(input logic [6:0] opcode);
      return (opcode == OPC_OP) || (opcode == OPC_OP_IMM);
   endfunction

endpackage

// File: rtl/philv_exec_ctrl_if.sv
// Connection bundle between the control/execute block and the surrounding
// datapath (IF register, register file, PC and EX registers).
interface philv_exec_ctrl_if;
   import philv_pkg::*;

   logic [BUS_WIDTH-1:0]       instr;
   logic [BUS_WIDTH-1:0]       pc;
   logic [BUS_WIDTH-1:0]       rs1_data;
   logic [BUS_WIDTH-1:0]       rs2_data;
   logic                       pc_write;
   logic                       ir_write;
   logic                       reg_wr_ena;
   logic                       alu_src_a_sel;
   logic [1:0]                 alu_src_b_sel;
   logic [ALU_FUNCT_WIDTH-1:0] alu_funct;
   logic [BUS_WIDTH-1:0]       alu_result;
   logic                       alu_zero;
   logic                       illegal_instr;

   modport master (
      input  instr, pc, rs1_data, rs2_data,
      output pc_write, ir_write, reg_wr_ena, alu_src_a_sel, alu_src_b_sel,
             alu_funct, alu_result, alu_zero, illegal_instr
   );

   modport slave (
      output instr, pc, rs1_data, rs2_data,
      input  pc_write, ir_write, reg_wr_ena, alu_src_a_sel, alu_src_b_sel,
             alu_funct, alu_result, alu_zero, illegal_instr
   );

endinterface

// File: rtl/philv_exec_ctrl_alu_core.sv
// Combinational 32-bit ALU; unassigned function codes yield zero.
module alu_core
   import philv_pkg::*;
(
   input  logic [ALU_FUNCT_WIDTH-1:0] funct,
   input  logic [BUS_WIDTH-1:0]       x,
   input  logic [BUS_WIDTH-1:0]       y,
   output logic [BUS_WIDTH-1:0]       z
);

   logic [4:0] shamt;
   assign shamt = y[4:0];

   // Select the operation result for the requested function code.
   always_comb begin
      z = 32'd0;
      case (funct)
         ALU_ADD:  z = x + y;
         ALU_SUB:  z = x - y;
         ALU_SLL:  z = x << shamt;
         ALU_SLT:  z = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
         ALU_SLTU: z = (x < y) ? 32'd1 : 32'd0;
         ALU_XOR:  z = x ^ y;
         ALU_SRL:  z = x >> shamt;
         ALU_SRA:  z = $unsigned($signed(x) >>> shamt);
         ALU_OR:   z = x | y;
         ALU_AND:  z = x & y;
         default:  z = 32'd0;
      endcase
   end

endmodule

// File: rtl/philv_exec_ctrl.sv
// PhilosophyV multicycle controller: four-state FSM, ALU function decoder,
// operand muxes and the ALU. All outputs are decoded from state and instr.
module philv_exec_ctrl
   import philv_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   philv_exec_ctrl_if.master bus
);

   state_e                     state;
   state_e                     state_next;
   logic [6:0]                 opcode;
   logic [2:0]                 funct3;
   logic                       funct7_b5;
   logic                       supported;
   alu_funct_e                 dec_funct;
   logic                       fsm_pc_write;
   logic                       fsm_ir_write;
   logic                       fsm_reg_wr;
   logic                       fsm_illegal;
   logic                       src_a_sel;
   logic [1:0]                 src_b_sel;
   logic [ALU_FUNCT_WIDTH-1:0] funct;
   logic [BUS_WIDTH-1:0]       src_a;
   logic [BUS_WIDTH-1:0]       src_b;
   logic [BUS_WIDTH-1:0]       imm_i;
   logic [BUS_WIDTH-1:0]       result;

   assign opcode    = bus.instr[OPCODE_MSB:OPCODE_LSB];
   assign funct3    = bus.instr[FUNCT3_MSB:FUNCT3_LSB];
   assign funct7_b5 = bus.instr[FUNCT7_LSB+5];
   assign supported = is_supported(opcode);
   assign imm_i     = {{20{bus.instr[31]}}, bus.instr[31:20]};

   // State register; reset restarts at FETCH and abandons any instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_FETCH;
      end else begin
         state <= state_next;
      end
   end

   // ALU function decode from funct3/funct7; immediate ops never subtract.
   always_comb begin
      dec_funct = ALU_ADD;
      if (supported) begin
         case (funct3)
            3'b000:  dec_funct = (opcode == OPC_OP && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  dec_funct = ALU_SLL;
            3'b010:  dec_funct = ALU_SLT;
            3'b011:  dec_funct = ALU_SLTU;
            3'b100:  dec_funct = ALU_XOR;
            3'b101:  dec_funct = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  dec_funct = ALU_OR;
            3'b111:  dec_funct = ALU_AND;
            default: dec_funct = ALU_ADD;
         endcase
      end else begin
         dec_funct = ALU_ADD;
      end
   end

   // Next-state and Moore control decode.
   always_comb begin
      state_next   = ST_FETCH;
      fsm_pc_write = 1'b0;
      fsm_ir_write = 1'b0;
      fsm_reg_wr   = 1'b0;
      fsm_illegal  = 1'b0;
      src_a_sel    = SRC_A_RS1;
      src_b_sel    = SRC_B_RS2;
      funct        = ALU_ADD;
      case (state)
         ST_FETCH: begin
            fsm_pc_write = 1'b1;
            fsm_ir_write = 1'b1;
            src_a_sel    = SRC_A_PC;
            src_b_sel    = SRC_B_FOUR;
            state_next   = ST_DECODE;
         end
         ST_DECODE: begin
            state_next = ST_EXECUTE;
         end
         ST_EXECUTE: begin
            src_b_sel   = (opcode == OPC_OP_IMM) ? SRC_B_IMM : SRC_B_RS2;
            funct       = dec_funct;
            fsm_illegal = ~supported;
            state_next  = supported ? ST_WRITEBACK : ST_FETCH;
         end
         ST_WRITEBACK: begin
            src_b_sel  = (opcode == OPC_OP_IMM) ? SRC_B_IMM : SRC_B_RS2;
            funct      = dec_funct;
            fsm_reg_wr = supported;
            state_next = ST_FETCH;
         end
         default: begin
            state_next = ST_FETCH;
         end
      endcase
   end

   // Operand muxes feeding the ALU.
   always_comb begin
      src_a = (src_a_sel == SRC_A_PC) ? bus.pc : bus.rs1_data;
      case (src_b_sel)
         SRC_B_RS2:  src_b = bus.rs2_data;
         SRC_B_FOUR: src_b = 32'd4;
         SRC_B_IMM:  src_b = imm_i;
         SRC_B_ZERO: src_b = 32'd0;
         default:    src_b = 32'd0;
      endcase
   end

   alu_core u_alu (
      .funct (funct),
      .x     (src_a),
      .y     (src_b),
      .z     (result)
   );

   // Enables are suppressed while reset is held so no write escapes an abort.
   assign bus.pc_write      = fsm_pc_write & ~rst;
   assign bus.ir_write      = fsm_ir_write & ~rst;
   assign bus.reg_wr_ena    = fsm_reg_wr & ~rst;
   assign bus.illegal_instr = fsm_illegal & ~rst;
   assign bus.alu_src_a_sel = src_a_sel;
   assign bus.alu_src_b_sel = src_b_sel;
   assign bus.alu_funct     = funct;
   assign bus.alu_result    = result;
   assign bus.alu_zero      = (result == 32'd0);

endmodule

// File: tb/tb_philv_exec_ctrl.sv
// Directed bench for philv_exec_ctrl: walks instructions through the four
// controller states and compares outputs against hand-computed values.
module tb_philv_exec_ctrl;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_pass;

   philv_exec_ctrl_if bus ();

   philv_exec_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; outputs are sampled on the falling edge.
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // From a FETCH cycle, load operands and move to EXECUTE.
   task automatic to_execute(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
      bus.instr    = ins;
      bus.rs1_data = a;
      bus.rs2_data = b;
      step();
      step();
   endtask

   initial begin
      n_checks     = 0;
      n_pass       = 0;
      rst          = 1'b1;
      bus.instr    = 32'h0000_0013;
      bus.pc       = 32'h0000_0100;
      bus.rs1_data = 32'd0;
      bus.rs2_data = 32'd0;

      // Reset held
      @(negedge clk);
      step();
      check_val("rst_pc_write", {31'd0, bus.pc_write}, 32'd0);
      check_val("rst_ir_write", {31'd0, bus.ir_write}, 32'd0);
      check_val("rst_reg_wr", {31'd0, bus.reg_wr_ena}, 32'd0);
      check_val("rst_illegal", {31'd0, bus.illegal_instr}, 32'd0);

      // Release: first cycle is FETCH computing pc+4
      rst = 1'b0;
      #1;
      check_val("fetch_pc_write", {31'd0, bus.pc_write}, 32'd1);
      check_val("fetch_ir_write", {31'd0, bus.ir_write}, 32'd1);
      check_val("fetch_src_b", {30'd0, bus.alu_src_b_sel}, 32'd1);
      check_val("fetch_pc_plus4", bus.alu_result, 32'h0000_0104);

      // ADD x3,x1,x2 with 5 + 7
      bus.instr = 32'h0020_81B3;
      bus.rs1_data = 32'd5;
      bus.rs2_data = 32'd7;
      step();
      check_val("decode_pc_write", {31'd0, bus.pc_write}, 32'd0);
      check_val("decode_src_a", {31'd0, bus.alu_src_a_sel}, 32'd1);
      step();
      check_val("add_funct", {28'd0, bus.alu_funct}, 32'd0);
      check_val("add_result", bus.alu_result, 32'd12);
      check_val("add_exec_reg_wr", {31'd0, bus.reg_wr_ena}, 32'd0);
      step();
      check_val("add_wb_reg_wr", {31'd0, bus.reg_wr_ena}, 32'd1);
      step();
      check_val("add_next_fetch", {31'd0, bus.pc_write}, 32'd1);
      check_val("add_next_reg_wr", {31'd0, bus.reg_wr_ena}, 32'd0);

      // SUB 0 - 1
      to_execute(32'h4020_81B3, 32'd0, 32'd1);
      check_val("sub_funct", {28'd0, bus.alu_funct}, 32'd1);
      check_val("sub_result", bus.alu_result, 32'hFFFF_FFFF);
      check_val("sub_zero0", {31'd0, bus.alu_zero}, 32'd0);
      step();
      step();
      // SUB 9 - 9
      to_execute(32'h4020_81B3, 32'd9, 32'd9);
      check_val("sub_eq_result", bus.alu_result, 32'd0);
      check_val("sub_zero1", {31'd0, bus.alu_zero}, 32'd1);
      step();
      step();

      // SRAI x1,x2,4 on 0x80000000
      to_execute(32'h4041_5093, 32'h8000_0000, 32'd0);
      check_val("srai_src_b", {30'd0, bus.alu_src_b_sel}, 32'd2);
      check_val("srai_funct", {28'd0, bus.alu_funct}, 32'd7);
      check_val("srai_result", bus.alu_result, 32'hF800_0000);
      step();
      check_val("srai_wb_reg_wr", {31'd0, bus.reg_wr_ena}, 32'd1);
      check_val("srai_wb_src_b", {30'd0, bus.alu_src_b_sel}, 32'd2);
      step();

      // ADDI x1,x0,0x7FF: instr[30] set must not select SUB
      to_execute(32'h7FF0_0093, 32'd1, 32'd0);
      check_val("addi_funct", {28'd0, bus.alu_funct}, 32'd0);
      check_val("addi_result", bus.alu_result, 32'h0000_0800);
      step();
      step();

      // SLT / SLTU with -1 vs 1
      to_execute(32'h0020_A1B3, 32'hFFFF_FFFF, 32'd1);
      check_val("slt_funct", {28'd0, bus.alu_funct}, 32'd3);
      check_val("slt_result", bus.alu_result, 32'd1);
      step();
      step();
      to_execute(32'h0020_B1B3, 32'hFFFF_FFFF, 32'd1);
      check_val("sltu_funct", {28'd0, bus.alu_funct}, 32'd4);
      check_val("sltu_result", bus.alu_result, 32'd0);
      step();
      step();

      // Unsupported opcode (load)
      to_execute(32'h0000_2183, 32'd3, 32'd4);
      check_val("illegal_flag", {31'd0, bus.illegal_instr}, 32'd1);
      check_val("illegal_reg_wr", {31'd0, bus.reg_wr_ena}, 32'd0);
      step();
      check_val("illegal_next_fetch", {31'd0, bus.pc_write}, 32'd1);
      check_val("illegal_cleared", {31'd0, bus.illegal_instr}, 32'd0);
      check_val("illegal_no_wb", {31'd0, bus.reg_wr_ena}, 32'd0);

      // Reset during EXECUTE of ADD
      to_execute(32'h0020_81B3, 32'd5, 32'd7);
      check_val("abort_in_exec", bus.alu_result, 32'd12);
      rst = 1'b1;
      #1;
      check_val("abort_reg_wr_a", {31'd0, bus.reg_wr_ena}, 32'd0);
      step();
      check_val("abort_reg_wr_b", {31'd0, bus.reg_wr_ena}, 32'd0);
      check_val("abort_pc_write_rst", {31'd0, bus.pc_write}, 32'd0);
      rst = 1'b0;
      #1;
      check_val("abort_fetch_pc_write", {31'd0, bus.pc_write}, 32'd1);
      check_val("abort_fetch_result", bus.alu_result, 32'h0000_0104);
      step();
      check_val("abort_decode_reg_wr", {31'd0, bus.reg_wr_ena}, 32'd0);
      check_val("abort_decode_pc_write", {31'd0, bus.pc_write}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/philv_exec_ctrl.md
Name: philv_exec_ctrl

Overview:
- Control and execute block of the PhilosophyV multicycle RV32I core.
- Contains three parts: a 4-state main controller FSM, an ALU function decoder (opcode/funct3/funct7), and a 32-bit ALU with its source-A and source-B operand muxes.
- Sits between the IF register (instruction, program count) and the register file / EX register.
- Produces the datapath enables (PC, IR, register-file write) and the ALU result.

Parameters:
- BUS_WIDTH, 32, datapath width; only 32 is supported.
- ALU_FUNCT_WIDTH, 4, width of the ALU function code.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- instr  in  32  current instruction (IF register output)
- pc  in  32  current program count
- rs1_data  in  32  register-file read port 0
- rs2_data  in  32  register-file read port 1
- pc_write  out  1  PC register enable
- ir_write  out  1  instruction register enable
- reg_wr_ena  out  1  register-file write enable
- alu_src_a_sel  out  1  0 = pc, 1 = rs1_data
- alu_src_b_sel  out  2  00 = rs2_data, 01 = constant 4, 10 = sign-extended instr[31:20], 11 = zero
- alu_funct  out  4  ALU function currently applied
- alu_result  out  32  combinational ALU output
- alu_zero  out  1  high when alu_result == 0
- illegal_instr  out  1  unsupported opcode flag, high in EXECUTE only

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, rst).
- FSM states: FETCH=0, DECODE=1, EXECUTE=2, WRITEBACK=3. Sequence is FETCH→DECODE→EXECUTE→WRITEBACK→FETCH, four cycles per instruction.
- Unsupported opcode: EXECUTE goes directly to FETCH, no write.
- Supported opcodes: OP = 0110011, OP-IMM = 0010011.
- Reset:
  - Next state is FETCH.
  - While rst is high: pc_write, ir_write, reg_wr_ena and illegal_instr are all 0.
  - Reset asserted in any state aborts the instruction; no register write occurs.
- All outputs are Moore (decoded from state plus instr), with no extra latency.
- FETCH: pc_write=1, ir_write=1, src_a=0, src_b=01, funct=ADD. The result pc+4 is captured by the PC register.
- DECODE: all enables 0; src_a=1, src_b=00, funct=ADD. Register-file read settles.
- EXECUTE: src_a=1; src_b=00 for OP, 10 for OP-IMM; funct from the decoder; enables 0. The EX register captures the result.
- WRITEBACK: reg_wr_ena=1 (OP/OP-IMM only); operand selects held as in EXECUTE.
- ALU codes:
  - ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9.
  - Codes 10–15 produce 0.
- Decoder, by funct3:
  - 000: OP → SUB if funct7[5], else ADD; OP-IMM → always ADD.
  - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
  - 101: SRA if funct7[5], else SRL (both OP and OP-IMM).
  - 110: OR. 111: AND.
  - Other opcodes: ADD.
- Arithmetic rules:
  - Add/sub are modulo 2^32; carry and overflow are discarded.
  - Shift amount is b[4:0].
  - SRA is an arithmetic shift.
  - SLT is a signed compare and SLTU an unsigned compare; result is 32'd1 or 32'd0.
- alu_zero reflects alu_result in every state.

Decomposition:
- Package philv_pkg holds:
  - ALU function codes and ALU_FUNCT_WIDTH.
  - Opcode constants (OP, OP-IMM).
  - FSM state encodings.
  - Source-select encodings.
  - Instruction field ranges (opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25]).
- One sub-module, alu_core: purely combinational (funct, x, y → z). Operand muxes, decoder and FSM stay in the top module.

Test Plan:
- Reset then release:
  - While rst is high, all enables are 0.
  - First cycle after release is FETCH: pc_write=ir_write=1; with pc=0x100, alu_result=0x104.
- R-type ADD (instr 0x002081B3), rs1=5, rs2=7:
  - EXECUTE: alu_funct=0, alu_result=12.
  - WRITEBACK: reg_wr_ena=1.
  - Next cycle: FETCH.
- SUB (funct7=0100000), rs1=0, rs2=1:
  - alu_result=0xFFFFFFFF, alu_zero=0.
  - Repeat with rs1=rs2=9: alu_result=0, alu_zero=1.
- SRAI x1,x2,4 (instr 0x40415093), rs1=0x80000000:
  - src_b=10, alu_funct=7, alu_result=0xF8000000.
- ADDI with imm=0x7FF (bit 10 set), rs1=1:
  - alu_funct=ADD (not SUB), alu_result=0x800.
- SLT vs SLTU with rs1=0xFFFFFFFF, rs2=1:
  - SLT → 1, SLTU → 0.
- Opcode 0000011:
  - illegal_instr=1 in EXECUTE, reg_wr_ena stays 0, next state FETCH.
- rst asserted during EXECUTE of ADD:
  - No reg_wr_ena pulse.
  - Following cycle after release is FETCH.
